vga_mode_timing: RTL and testbench

VGA_MODE_TIMING -- requirements
Module: vga_mode_timing

---
 rtl/vga_timing_pkg.sv | 76 +++++++
 rtl/vga_delay_line.sv | 26 ++
 rtl/vga_mode_timing.sv | 153 +++++++++++++++
 tb/tb_vga_mode_timing.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: mode table, test-bar geometry and bar colours
// shared by the VGA timing generator.
package vga_timing_pkg;

    typedef logic [15:0] tval_t;

    typedef struct packed {
        tval_t h_sync;
        tval_t h_bp;
        tval_t h_disp;
        tval_t h_fp;
        tval_t v_sync;
        tval_t v_bp;
        tval_t v_disp;
        tval_t v_fp;
        logic  pol;
    } mode_t;

    localparam mode_t MODE_640 = '{
        h_sync: 16'd96,  h_bp: 16'd48,  h_disp: 16'd640,  h_fp: 16'd16,
        v_sync: 16'd2,   v_bp: 16'd33,  v_disp: 16'd480,  v_fp: 16'd10,
        pol: 1'b0
    };

    localparam mode_t MODE_800 = '{
        h_sync: 16'd128, h_bp: 16'd88,  h_disp: 16'd800,  h_fp: 16'd40,
        v_sync: 16'd4,   v_bp: 16'd23,  v_disp: 16'd600,  v_fp: 16'd1,
        pol: 1'b1
    };

    localparam mode_t MODE_1024 = '{
        h_sync: 16'd136, h_bp: 16'd160, h_disp: 16'd1024, h_fp: 16'd24,
        v_sync: 16'd6,   v_bp: 16'd29,  v_disp: 16'd768,  v_fp: 16'd3,
        pol: 1'b0
    };

    // Bar width per mode: one eighth of the active width.
    localparam tval_t BAR_W_640  = 16'd80;
    localparam tval_t BAR_W_800  = 16'd100;
    localparam tval_t BAR_W_1024 = 16'd128;

    // {r,g,b}: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [0:7][2:0] BAR_RGB = {
        3'b111, 3'b110, 3'b011, 3'b010,
        3'b101, 3'b100, 3'b001, 3'b000
    };

    function automatic mode_t mode_params(input logic [1:0] m);
        unique case (m)
            2'd1:    return MODE_800;
            2'd2:    return MODE_1024;
            default: return MODE_640;
        endcase
    endfunction

    function automatic tval_t bar_width(input logic [1:0] m);
        unique case (m)
            2'd1:    return BAR_W_800;
            2'd2:    return BAR_W_1024;
            default: return BAR_W_640;
        endcase
    endfunction

    function automatic logic [2:0] bar_index(input tval_t x, input tval_t w);
        logic [2:0] idx;
        tval_t      bnd;
        idx = 3'd0;
        bnd = w;
        for (int k = 1; k < 8; k++) begin
            if (x >= bnd) idx = 3'(k);
            bnd = bnd + w;
        end
        return idx;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: fixed-depth shift register with asynchronous clear,
// used to line up sync/DE with the pixel fetch latency.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/vga_mode_timing.sv
// vga_mode_timing: 640x480/800x600/1024x768 timing generator with frame-aligned
// mode switching. Define VGA_TESTBAR_EN to add the test_en colour-bar source.
module vga_mode_timing
    import vga_timing_pkg::*;
#(
    parameter int COORD_W  = 11,
    parameter int RGB_W    = 12,
    parameter int PIPE_LAT = 1
) (
    input  logic               vga_clk,
    input  logic               sys_rst,
    input  logic [1:0]         mode_sel,
    input  logic [RGB_W-1:0]   pixel_data,
`ifdef VGA_TESTBAR_EN
    input  logic               test_en,
`endif
    output logic               pixel_req,
    output logic [COORD_W-1:0] pixel_xpos,
    output logic [COORD_W-1:0] pixel_ypos,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_de,
    output logic [RGB_W-1:0]   vga_rgb,
    output logic [COORD_W-1:0] h_disp,
    output logic [COORD_W-1:0] v_disp,
    output logic [1:0]         mode_cur,
    output logic               frame_start
);

    localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);
    localparam int CW = RGB_W / 3;
`ifdef VGA_TESTBAR_EN
    localparam int DW = 7;
`else
    localparam int DW = 4;
`endif

    mode_t              m;
    logic [1:0]         mode_pend;
    logic [COORD_W-1:0] h_cnt, v_cnt;
    logic [COORD_W-1:0] h_sync, h_as, h_ae, h_last;
    logic [COORD_W-1:0] v_sync, v_as, v_ae, v_last;
    logic               h_vis, v_vis, vis;
    logic [COORD_W-1:0] x_next, y_next;
    logic               hs_act, vs_act, pol_s;
    logic [DW-1:0]      dl_d, dl_q;
    logic [RGB_W-1:0]   src_rgb;

    assign m      = mode_params(mode_cur);
    assign h_sync = COORD_W'(m.h_sync);
    assign h_as   = COORD_W'(m.h_sync + m.h_bp);
    assign h_ae   = COORD_W'(m.h_sync + m.h_bp + m.h_disp);
    assign h_last = COORD_W'(m.h_sync + m.h_bp + m.h_disp + m.h_fp - 16'd1);
    assign v_sync = COORD_W'(m.v_sync);
    assign v_as   = COORD_W'(m.v_sync + m.v_bp);
    assign v_ae   = COORD_W'(m.v_sync + m.v_bp + m.v_disp);
    assign v_last = COORD_W'(m.v_sync + m.v_bp + m.v_disp + m.v_fp - 16'd1);
    assign h_disp = COORD_W'(m.h_disp);
    assign v_disp = COORD_W'(m.v_disp);

    // Gated by reset so the pulse lands on the first cycle after release.
    assign frame_start = ~sys_rst & (h_cnt == '0) & (v_cnt == '0);

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            mode_cur  <= 2'd0;
            mode_pend <= 2'd0;
        end else begin
            mode_pend <= (mode_sel == 2'd3) ? 2'd0 : mode_sel;
            if (h_cnt == h_last) begin
                h_cnt <= '0;
                if (v_cnt == v_last) begin
                    v_cnt    <= '0;
                    mode_cur <= mode_pend;
                end else begin
                    v_cnt <= v_cnt + C_ONE;
                end
            end else begin
                h_cnt <= h_cnt + C_ONE;
            end
        end
    end

    assign h_vis  = (h_cnt >= h_as) && (h_cnt < h_ae);
    assign v_vis  = (v_cnt >= v_as) && (v_cnt < v_ae);
    assign vis    = h_vis & v_vis;
    assign x_next = vis ? h_cnt - h_as : '0;
    assign y_next = vis ? v_cnt - v_as : '0;

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pixel_req  <= 1'b0;
            pixel_xpos <= '0;
            pixel_ypos <= '0;
            hs_act     <= 1'b0;
            vs_act     <= 1'b0;
            pol_s      <= 1'b0;
        end else begin
            pixel_req  <= vis;
            pixel_xpos <= x_next;
            pixel_ypos <= y_next;
            hs_act     <= h_cnt < h_sync;
            vs_act     <= v_cnt < v_sync;
            pol_s      <= m.pol;
        end
    end

`ifdef VGA_TESTBAR_EN
    logic [2:0] bar_s;
    logic [2:0] bar_c;

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) bar_s <= 3'd0;
        else         bar_s <= bar_index(tval_t'(x_next), bar_width(mode_cur));
    end

    assign dl_d    = {bar_s, pol_s, vs_act, hs_act, pixel_req};
    assign bar_c   = BAR_RGB[dl_q[6:4]];
    assign src_rgb = test_en ? {{CW{bar_c[2]}}, {CW{bar_c[1]}}, {CW{bar_c[0]}}}
                             : pixel_data;
`else
    assign dl_d    = {pol_s, vs_act, hs_act, pixel_req};
    assign src_rgb = pixel_data;
`endif

    vga_delay_line #(
        .WIDTH (DW),
        .DEPTH (PIPE_LAT)
    ) u_align (
        .clk (vga_clk),
        .rst (sys_rst),
        .d   (dl_d),
        .q   (dl_q)
    );

    // Sync levels are stored polarity-free so a cleared line reads inactive.
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vga_de  <= 1'b0;
            vga_hs  <= 1'b1;
            vga_vs  <= 1'b1;
            vga_rgb <= '0;
        end else begin
            vga_de  <= dl_q[0];
            vga_hs  <= dl_q[1] ~^ dl_q[3];
            vga_vs  <= dl_q[2] ~^ dl_q[3];
            vga_rgb <= dl_q[0] ? src_rgb : '0;
        end
    end

endmodule

// File: tb/tb_vga_mode_timing.sv
// tb_vga_mode_timing: directed checks of reset, frame timing, pixel alignment,
// mode switching and (with VGA_TESTBAR_EN) the colour bars.
module tb_vga_mode_timing;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [1:0]  mode_sel = 2'd0;
    logic [11:0] pixel_data = 12'h000;
    logic        pixel_req;
    logic [10:0] pixel_xpos, pixel_ypos;
    logic        vga_hs, vga_vs, vga_de;
    logic [11:0] vga_rgb;
    logic [10:0] h_disp, v_disp;
    logic [1:0]  mode_cur;
    logic        frame_start;
`ifdef VGA_TESTBAR_EN
    logic        test_en = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    logic [11:0] src1 = 12'h000, src2 = 12'h000;

    vga_mode_timing #(
        .COORD_W  (11),
        .RGB_W    (12),
        .PIPE_LAT (3)
    ) dut (
        .vga_clk     (clk),
        .sys_rst     (sys_rst),
        .mode_sel    (mode_sel),
        .pixel_data  (pixel_data),
`ifdef VGA_TESTBAR_EN
        .test_en     (test_en),
`endif
        .pixel_req   (pixel_req),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_de      (vga_de),
        .vga_rgb     (vga_rgb),
        .h_disp      (h_disp),
        .v_disp      (v_disp),
        .mode_cur    (mode_cur),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Content source with a three-cycle fetch pipeline.
    always @(posedge clk) begin
        src1       <= {pixel_xpos[3:0], pixel_ypos[3:0], 4'h0};
        src2       <= src1;
        pixel_data <= src2;
    end

    task automatic test_reset();
        sys_rst  = 1'b1;
        mode_sel = 2'd2;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (pixel_req !== 1'b0) begin
            failures++; $display("FAIL reset_pixel_req got=%b exp=0", pixel_req);
        end
        checks++;
        if (vga_de !== 1'b0 || vga_rgb !== 12'h000) begin
            failures++; $display("FAIL reset_de_rgb got=%b/%h exp=0/000", vga_de, vga_rgb);
        end
        checks++;
        if (vga_hs !== 1'b1 || vga_vs !== 1'b1) begin
            failures++; $display("FAIL reset_sync got=%b%b exp=11", vga_hs, vga_vs);
        end
        checks++;
        if (frame_start !== 1'b0) begin
            failures++; $display("FAIL reset_frame_start got=%b exp=0", frame_start);
        end
        checks++;
        if (mode_cur !== 2'd0 || h_disp !== 11'd640 || v_disp !== 11'd480) begin
            failures++;
            $display("FAIL reset_mode got=%0d %0d %0d exp=0 640 480", mode_cur, h_disp, v_disp);
        end
        mode_sel = 2'd0;
        @(negedge clk);
        sys_rst = 1'b0;
        #1;
        checks++;
        if (frame_start !== 1'b1) begin
            failures++; $display("FAIL release_frame_start got=%b exp=1", frame_start);
        end
    endtask

    task automatic test_midframe_reset();
        repeat (160300) @(negedge clk);
        #1;
        checks++;
        if (vga_de !== 1'b1 || vga_rgb !== 12'h750) begin
            failures++; $display("FAIL line200_pixel got=%b/%h exp=1/750", vga_de, vga_rgb);
        end
        sys_rst = 1'b1;
        #1;
        checks++;
        if (vga_de !== 1'b0 || vga_rgb !== 12'h000 || pixel_req !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs got=%b/%h/%b exp=0/000/0", vga_de, vga_rgb, pixel_req);
        end
        checks++;
        if (vga_hs !== 1'b1 || vga_vs !== 1'b1 || pixel_ypos !== 11'd0) begin
            failures++;
            $display("FAIL midreset_sync got=%b%b y=%0d exp=11 y=0", vga_hs, vga_vs, pixel_ypos);
        end
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
        #1;
        checks++;
        if (frame_start !== 1'b1) begin
            failures++; $display("FAIL midreset_restart got=%b exp=1", frame_start);
        end
    endtask

    task automatic test_frame_mode0();
        int de_n = 0, hs_lo = 0, vs_lo = 0, req_n = 0, fs_n = 0;
        int first_de = -1, bad_pix = 0, bad_blank = 0, bad_coord = 0, bad_mode = 0;
        int x, y;
        logic [11:0] exp_rgb;
        for (int c = 0; c < 420000; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            if (c == 100000) mode_sel = 2'd2;
            if (c == 200000) mode_sel = 2'd0;
            if (frame_start) fs_n++;
            if (!vga_hs) hs_lo++;
            if (!vga_vs) vs_lo++;
            if (pixel_req) req_n++;
            else if (pixel_xpos != 0 || pixel_ypos != 0) bad_coord++;
            if (mode_cur != 2'd0 || h_disp != 11'd640) bad_mode++;
            if (vga_de) begin
                if (first_de < 0) first_de = c;
                x = de_n % 640;
                y = de_n / 640;
                exp_rgb = {x[3:0], y[3:0], 4'h0};
                if (vga_rgb !== exp_rgb) begin
                    if (bad_pix == 0)
                        $display("FAIL pixel_value n=%0d got=%h exp=%h", de_n, vga_rgb, exp_rgb);
                    bad_pix++;
                end
                de_n++;
            end else if (vga_rgb !== 12'h000) begin
                bad_blank++;
            end
        end
        checks++;
        if (de_n !== 307200) begin
            failures++; $display("FAIL de_count got=%0d exp=307200", de_n);
        end
        checks++;
        if (hs_lo !== 50400) begin
            failures++; $display("FAIL hs_low_count got=%0d exp=50400", hs_lo);
        end
        checks++;
        if (vs_lo !== 1600) begin
            failures++; $display("FAIL vs_low_count got=%0d exp=1600", vs_lo);
        end
        checks++;
        if (req_n !== 307200 || bad_coord !== 0) begin
            failures++; $display("FAIL req_count got=%0d/%0d exp=307200/0", req_n, bad_coord);
        end
        checks++;
        if (first_de !== 28149) begin
            failures++; $display("FAIL first_de_cycle got=%0d exp=28149", first_de);
        end
        checks++;
        if (bad_pix !== 0) begin
            failures++; $display("FAIL pixel_mismatches got=%0d exp=0", bad_pix);
        end
        checks++;
        if (bad_blank !== 0) begin
            failures++; $display("FAIL blank_rgb got=%0d exp=0", bad_blank);
        end
        checks++;
        if (fs_n !== 1 || bad_mode !== 0) begin
            failures++; $display("FAIL toggle_no_switch got=%0d/%0d exp=1/0", fs_n, bad_mode);
        end
        @(negedge clk);
        #1;
        checks++;
        if (frame_start !== 1'b1 || mode_cur !== 2'd0) begin
            failures++;
            $display("FAIL frame_wrap got=%b/%0d exp=1/0", frame_start, mode_cur);
        end
    endtask

    task automatic test_mode_switch();
        int hs_hi = 0;
        for (int k = 1; k < 420000; k++) begin
            @(negedge clk);
            #1;
            if (k == 1000) mode_sel = 2'd1;
        end
        checks++;
        if (mode_cur !== 2'd0 || h_disp !== 11'd640 || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL pre_switch got=%0d/%0d/%b exp=0/640/0", mode_cur, h_disp, frame_start);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mode_cur !== 2'd1 || h_disp !== 11'd800 || v_disp !== 11'd600 || frame_start !== 1'b1) begin
            failures++;
            $display("FAIL switch got=%0d/%0d/%0d/%b exp=1/800/600/1",
                     mode_cur, h_disp, v_disp, frame_start);
        end
        for (int c = 1; c <= 28750; c++) begin
            @(negedge clk);
            #1;
            if (c >= 5 && c < 1061 && vga_hs) hs_hi++;
            if (c == 1060) begin
                checks++;
                if (vga_hs !== 1'b0) begin
                    failures++; $display("FAIL m1_hs_inactive got=%b exp=0", vga_hs);
                end
            end
            if (c == 1061) begin
                checks++;
                if (vga_hs !== 1'b1) begin
                    failures++; $display("FAIL m1_line_period got=%b exp=1", vga_hs);
                end
            end
            if (c == 10 || c == 4228 || c == 4229) begin
                checks++;
                if (vga_vs !== (c != 4229)) begin
                    failures++; $display("FAIL m1_vs c=%0d got=%b exp=%b", c, vga_vs, c != 4229);
                end
            end
            if (c == 28732 || c == 28733) begin
                checks++;
                if (vga_de !== (c == 28733)) begin
                    failures++; $display("FAIL m1_de_start c=%0d got=%b exp=%b", c, vga_de, c == 28733);
                end
            end
            if (c == 28750) begin
                checks++;
                if (vga_rgb !== 12'h100) begin
                    failures++; $display("FAIL m1_pixel got=%h exp=100", vga_rgb);
                end
            end
        end
        checks++;
        if (hs_hi !== 128) begin
            failures++; $display("FAIL m1_hs_width got=%0d exp=128", hs_hi);
        end
    endtask

`ifdef VGA_TESTBAR_EN
    task automatic test_testbar();
        @(negedge clk);
        sys_rst  = 1'b1;
        mode_sel = 2'd0;
        test_en  = 1'b1;
        repeat (2) @(negedge clk);
        sys_rst = 1'b0;
        #1;
        for (int c = 1; c <= 28788; c++) begin
            @(negedge clk);
            #1;
            if (c == 28149) begin
                checks++;
                if (vga_rgb !== 12'hFFF) begin
                    failures++; $display("FAIL bar_px0 got=%h exp=FFF", vga_rgb);
                end
            end
            if (c == 28229) begin
                checks++;
                if (vga_rgb !== 12'hFF0) begin
                    failures++; $display("FAIL bar_px80 got=%h exp=FF0", vga_rgb);
                end
            end
            if (c == 28788) begin
                checks++;
                if (vga_rgb !== 12'h000 || vga_de !== 1'b1) begin
                    failures++; $display("FAIL bar_px639 got=%h/%b exp=000/1", vga_rgb, vga_de);
                end
            end
        end
        test_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_midframe_reset();
        test_frame_mode0();
        test_mode_switch();
`ifdef VGA_TESTBAR_EN
        test_testbar();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
